// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
//
// Multi-channel programmable clock divider / one-shot interval timer.
// Each channel is fully independent. It produces one of two outputs:
//   - mode 0: a free-running square wave of period 2*half cycles.
//   - mode 1: a single high pulse lasting exactly half cycles, which
//     can be retriggered while it is running.
// Each channel also emits a one-cycle tick strobe at every terminal count.
// Consumers can therefore stay in the clk domain.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active-low
//   en       : per-channel run enable (0 freezes counter/outputs, tick=0)
//   clr      : per-channel synchronous clear (half register is kept)
//   mode     : per-channel mode, 0 = divider, 1 = one-shot
//   start    : per-channel one-shot trigger (used in mode 1 only)
//   load     : per-channel write strobe for the half-period register
//   half_in  : half-period values, channel i uses [i*CW +: CW]
//   clk_out  : divided clock / timed pulse (registered)
//   tick     : one-cycle terminal strobe (registered)
//   busy     : one-shot in progress (registered, 0 in mode 0)
// ---------------------------------------------------------------------------
module clk_div_multi #(
    parameter int CH       = 2,
    parameter int CW       = 27,
    parameter int DEF_HALF = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    en,
    input  logic [CH-1:0]    clr,
    input  logic [CH-1:0]    mode,
    input  logic [CH-1:0]    start,
    input  logic [CH-1:0]    load,
    input  logic [CH*CW-1:0] half_in,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    busy
);

    typedef enum logic {
        OS_IDLE = 1'b0,
        OS_RUN  = 1'b1
    } os_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [CW-1:0] cnt_q, cnt_d;
            logic [CW-1:0] half_q, half_d;
            logic [CW-1:0] half_slice;
            logic          mode_q, mode_d;
            logic          clk_q, clk_d;
            logic          tick_q, tick_d;
            os_state_t     state_q, state_d;
            logic          term;

            assign half_slice = half_in[gi*CW +: CW];

            // half_q is never 0, so half_q-1 cannot underflow. Using >=
            // forces a wrap when half is lowered below the running count.
            assign term = (cnt_q >= (half_q - CW'(1)));

            always_comb begin
                cnt_d   = cnt_q;
                clk_d   = clk_q;
                state_d = state_q;
                tick_d  = 1'b0;
                mode_d  = mode[gi];

                // A load is independent of clear, enable and mode. A zero
                // value is promoted to 1 so that the terminal compare stays
                // meaningful.
                if (load[gi]) begin
                    half_d = (half_slice == '0) ? CW'(1) : half_slice;
                end else begin
                    half_d = half_q;
                end

                if (clr[gi] || (mode[gi] != mode_q)) begin
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    state_d = OS_IDLE;
                end else if (en[gi]) begin
                    if (!mode_q) begin
                        if (term) begin
                            cnt_d  = '0;
                            clk_d  = ~clk_q;
                            tick_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        if (start[gi]) begin
                            // Fresh start and retrigger both restart the interval.
                            cnt_d   = '0;
                            clk_d   = 1'b1;
                            state_d = OS_RUN;
                        end else if (state_q == OS_RUN) begin
                            if (term) begin
                                cnt_d   = '0;
                                clk_d   = 1'b0;
                                state_d = OS_IDLE;
                                tick_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q   <= '0;
                    half_q  <= CW'(DEF_HALF);
                    mode_q  <= 1'b0;
                    clk_q   <= 1'b0;
                    tick_q  <= 1'b0;
                    state_q <= OS_IDLE;
                end else begin
                    cnt_q   <= cnt_d;
                    half_q  <= half_d;
                    mode_q  <= mode_d;
                    clk_q   <= clk_d;
                    tick_q  <= tick_d;
                    state_q <= state_d;
                end
            end

            assign clk_out[gi] = clk_q;
            assign tick[gi]    = tick_q;
            assign busy[gi]    = (state_q == OS_RUN);
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
//
// Directed bench for clk_div_multi with CH=2, CW=8, DEF_HALF=4.
// Expected waveforms are hand-derived per clock edge. They are written as
// character strings, where character i is the value after the i-th edge.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int CH = 2;
    localparam int CW = 8;

    logic             clk;
    logic             rst;
    logic [CH-1:0]    en;
    logic [CH-1:0]    clr;
    logic [CH-1:0]    mode;
    logic [CH-1:0]    start;
    logic [CH-1:0]    load;
    logic [CH*CW-1:0] half_in;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    busy;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_multi #(
        .CH      (CH),
        .CW      (CW),
        .DEF_HALF(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (clr),
        .mode   (mode),
        .start  (start),
        .load   (load),
        .half_in(half_in),
        .clk_out(clk_out),
        .tick   (tick),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step n edges, checking channel ch against the per-edge strings.
    task automatic expect_seq(input string tag, input int ch, input int n,
                              input string ec, input string et, input string eb);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s[%0d].clk_out", tag, i), 32'(clk_out[ch]), 32'(ec[i] == "1"));
            chk($sformatf("%s[%0d].tick", tag, i),    32'(tick[ch]),    32'(et[i] == "1"));
            chk($sformatf("%s[%0d].busy", tag, i),    32'(busy[ch]),    32'(eb[i] == "1"));
        end
    endtask

    // One edge, checking both channels' clk_out and tick.
    task automatic step2(input string tag, input logic c0, input logic t0,
                         input logic c1, input logic t1);
        step();
        chk({tag, ".ch0.clk_out"}, 32'(clk_out[0]), 32'(c0));
        chk({tag, ".ch0.tick"},    32'(tick[0]),    32'(t0));
        chk({tag, ".ch1.clk_out"}, 32'(clk_out[1]), 32'(c1));
        chk({tag, ".ch1.tick"},    32'(tick[1]),    32'(t1));
    endtask

    initial begin
        rst     = 1'b0;
        en      = '0;
        clr     = '0;
        mode    = '0;
        start   = '0;
        load    = '0;
        half_in = '0;

        #2;
        chk("reset.clk_out", 32'(clk_out), 32'd0);
        chk("reset.tick",    32'(tick),    32'd0);
        chk("reset.busy",    32'(busy),    32'd0);

        // Release between edges; both channels free-run with half=4.
        #10;
        rst = 1'b1;
        en  = 2'b11;
        expect_seq("run6", 0, 6, "000111", "000100", "000000");

        // Asynchronous reset in mid-cycle, while clk_out is high.
        #2;
        rst = 1'b0;
        #2;
        chk("async_rst.clk_out", 32'(clk_out), 32'd0);
        chk("async_rst.tick",    32'(tick),    32'd0);
        chk("async_rst.busy",    32'(busy),    32'd0);
        #1;
        rst = 1'b1;

        // First toggle 4 edges after release, period 8, tick at each toggle.
        expect_seq("freerun", 0, 8, "00011110", "00010001", "00000000");

        // Freeze ch0 at cnt=2 for 3 cycles: low phase stretches to 7.
        expect_seq("pre_freeze", 0, 2, "00", "00", "00");
        en[0] = 1'b0;
        expect_seq("freeze", 0, 3, "000", "000", "000");
        en[0] = 1'b1;
        expect_seq("unfreeze", 0, 2, "01", "01", "00");

        // Reload to 2 while cnt=2. The count lands at 3, which is past the
        // new terminal, so the wrap comes on the next edge.
        expect_seq("pre_load", 0, 2, "11", "00", "00");
        load[0]       = 1'b1;
        half_in[0 +: CW] = 8'd2;
        expect_seq("load2", 0, 1, "1", "0", "0");
        load[0] = 1'b0;
        expect_seq("half2", 0, 5, "00110", "10101", "00000");

        // Load 0 -> treated as 1: toggles every cycle.
        load[0]       = 1'b1;
        half_in[0 +: CW] = 8'd0;
        expect_seq("load0", 0, 1, "0", "0", "0");
        load[0] = 1'b0;
        expect_seq("half1", 0, 3, "101", "111", "000");

        // One-shot with half=5. The mode change clears the channel, and the
        // load in the same cycle still applies.
        mode[0]       = 1'b1;
        load[0]       = 1'b1;
        half_in[0 +: CW] = 8'd5;
        expect_seq("mode1", 0, 1, "0", "0", "0");
        load[0]  = 1'b0;
        start[0] = 1'b1;
        expect_seq("os_start", 0, 1, "1", "0", "1");
        start[0] = 1'b0;
        expect_seq("os_run", 0, 6, "111100", "000010", "111100");

        // Retrigger on the 4th high cycle: 8 high cycles in total.
        start[0] = 1'b1;
        expect_seq("rt_start", 0, 1, "1", "0", "1");
        start[0] = 1'b0;
        expect_seq("rt_run", 0, 2, "11", "00", "11");
        start[0] = 1'b1;
        expect_seq("rt_retrig", 0, 1, "1", "0", "1");
        start[0] = 1'b0;
        expect_seq("rt_tail", 0, 6, "111100", "000010", "111100");

        // Independence: ch0 back to mode 0 with half=3; ch1 cleared with half=2.
        mode[0]          = 1'b0;
        load             = 2'b11;
        half_in[0 +: CW]  = 8'd3;
        half_in[CW +: CW] = 8'd2;
        clr[1]           = 1'b1;
        step2("ind0", 0, 0, 0, 0);
        load   = '0;
        clr[1] = 1'b0;
        step2("ind1", 0, 0, 0, 0);
        step2("ind2", 0, 0, 1, 1);
        step2("ind3", 1, 1, 1, 0);
        step2("ind4", 1, 0, 0, 1);
        clr[1] = 1'b1;
        step2("ind5_clr1", 1, 0, 0, 0);
        clr[1] = 1'b0;
        step2("ind6", 0, 1, 0, 0);
        mode[1] = 1'b1;
        step2("ind7_mode1", 0, 0, 0, 0);
        step2("ind8", 0, 0, 0, 0);
        chk("ind8.ch1.busy", 32'(busy[1]), 32'd0);
        step2("ind9", 1, 1, 0, 0);
        step2("ind10", 1, 0, 0, 0);
        step2("ind11", 1, 0, 0, 0);
        step2("ind12", 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, run-time programmable clock divider and one-shot interval timer for the Morse pipeline. Each channel produces a slow square clock or a single timed pulse, such as a dot/dash/gap interval, from the 200 MHz system clock. Each channel also emits a one-cycle `tick` strobe, so consumers can stay in the `clk` domain instead of clocking logic from a divided clock. It generalises the fixed-period divider: per-channel period registers, an enable that freezes state, a synchronous clear, and a one-shot mode.

## Interface
- `CH`, 2: number of independent channels.
- `CW`, 27: counter and half-period width. Must satisfy 2^CW > DEF_HALF.
- `DEF_HALF`, 100_000_000: reset value of every channel's half-period register, in `clk` cycles.

- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous reset, **active-low**.
- `en` in CH: per-channel run enable; 0 freezes that channel.
- `clr` in CH: per-channel synchronous clear.
- `mode` in CH: 0 = free-running divider, 1 = one-shot timer.
- `start` in CH: one-shot trigger, sampled when mode=1.
- `load` in CH: write `half_in` slice into the channel's half-period register.
- `half_in` in CH*CW: channel i uses bits [i*CW +: CW].
- `clk_out` out CH: divided clock (mode 0) or timed pulse (mode 1); registered.
- `tick` out CH: one-cycle strobe at each terminal count; registered.
- `busy` out CH: one-shot in progress; always 0 in mode 0.

## Operation
- Per-channel state: `cnt`[CW], `half`[CW], `mode_q`, `clk_out`, `tick`, `busy`.
- Terminal condition: `cnt >= half-1`. Using `>=` guarantees a wrap after `half` is lowered below the current count.
- Load: `half <= (half_in==0) ? 1 : half_in`, applied at the edge, independent of `en`. The new value is used for the compare from the next cycle.
- `tick` defaults to 0 every cycle and is set only at a terminal event.
- Priority per channel: `clr` > mode change > `start` > counting.
  - **`clr`**: cnt=0, clk_out=0, busy=0, tick=0. `half` is kept. `load` in the same cycle still applies.
  - **Mode change**: when `mode != mode_q`, the channel is cleared as for `clr`, then `mode_q <= mode`.
  - **`en`=0**: cnt, clk_out and busy hold; tick=0; `start` is ignored.
- Mode 0, en=1:
  - Terminal: cnt=0, clk_out toggles, tick=1.
  - Otherwise: cnt+1.
  - Output period is 2*half cycles; half=1 gives clk/2.
- Mode 1 (states IDLE = busy 0, RUN = busy 1), en=1:
  - IDLE + start: go to RUN; cnt=0, clk_out=1, busy=1.
  - RUN + start (retrigger): cnt=0, remain in RUN.
  - RUN + terminal: go to IDLE; cnt=0, clk_out=0, busy=0, tick=1.
  - RUN otherwise: cnt+1.
  - IDLE with no start: all state holds at 0.
- Channels share nothing except `clk` and `rst`.

## Timing
- Reset (rst=0, asynchronous): cnt=0, clk_out=0, tick=0, busy=0, mode_q=0, half=DEF_HALF. Outputs go to 0 without waiting for a clock edge.
- Mode 0: `clk_out` toggles every `half` enabled cycles. `tick` is high in the same cycle as the new `clk_out` level (both set at the same edge).
- Mode 1: start accepted at edge k gives `clk_out` and `busy` high from k through edge k+half, i.e. exactly `half` cycles; `tick` is high for the one cycle after edge k+half.
- Each `en`=0 cycle lengthens the current phase by exactly one cycle.
- Clear latency: outputs are 0 in the cycle after the `clr` edge.

## Test plan
- **Reset**: DEF_HALF=4, run 6 cycles, pull rst low between edges -> clk_out, tick, busy read 0 before the next edge; after release the first toggle comes 4 cycles later.
- **Free-run**: DEF_HALF=4, en=1 -> clk_out period 8 with 4 high / 4 low; tick one cycle wide at every toggle (2 per period).
- **Freeze**: en=0 for 3 cycles at cnt=2 -> clk_out and cnt hold; that phase lasts 7 cycles; no tick while frozen.
- **Reload**: at cnt=3 with half=4, load 2 -> terminal on the next cycle, then toggles every 2 cycles. Load 0 -> toggles every cycle.
- **One-shot**: mode=1, half=5, start pulse -> clk_out and busy high 5 cycles, tick in cycle 6. Retrigger start at cycle 3 -> high 8 cycles total.
- **Independence**: CH=2 with different halves. clr and a mode change on ch1 mid-run leave ch0's cnt, clk_out and tick cadence unchanged.
